// File: rtl/sram_ctrl.sv
// Single-port controller for the external asynchronous SRAM.
// Sequences CS/OE/WE and bus direction with programmable access timing.
module sram_ctrl #(
    parameter int ACCESS_CYCLES = 2,
    parameter int TURN_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [18:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [18:0] sram_adr,
    output logic [15:0] sram_dat_o,
    input  logic [15:0] sram_dat_i,
    output logic        sram_dat_oe,
    output logic        sram_cs_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_TURN
    } state_t;

    localparam logic [3:0] LP_ACC  = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] LP_TURN = 4'(TURN_CYCLES - 1);

    state_t      r_state;
    state_t      w_nxt_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_nxt_cnt;
    logic        w_accept;
    logic        w_rd_done;

    logic        w_cs_n;
    logic        w_oe_n;
    logic        w_we_n;
    logic        w_dat_oe;

    logic        r_cs_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_dat_oe;
    logic [18:0] r_adr;
    logic [15:0] r_dat_o;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_rd_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        w_nxt_state = S_WR_SETUP;
                        w_nxt_cnt   = 4'd0;
                    end else begin
                        w_nxt_state = S_RD;
                        w_nxt_cnt   = LP_ACC;
                    end
                end
            end
            S_RD: begin
                if (r_cnt == 4'd0) begin
                    w_rd_done = 1'b1;
                    if (TURN_CYCLES > 0) begin
                        w_nxt_state = S_TURN;
                        w_nxt_cnt   = LP_TURN;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end
            end
            S_WR_SETUP: begin
                w_nxt_state = S_WR_PULSE;
                w_nxt_cnt   = LP_ACC;
            end
            S_WR_PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_nxt_state = S_WR_HOLD;
                end else begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end
            end
            S_WR_HOLD: begin
                w_nxt_state = S_IDLE;
            end
            S_TURN: begin
                if (r_cnt == 4'd0) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = 4'd0;
            end
        endcase
    end

    // Strobes decoded from the next state so they register glitch-free.
    always_comb begin
        w_cs_n   = 1'b1;
        w_oe_n   = 1'b1;
        w_we_n   = 1'b1;
        w_dat_oe = 1'b0;
        unique case (w_nxt_state)
            S_RD: begin
                w_cs_n = 1'b0;
                w_oe_n = 1'b0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                w_cs_n   = 1'b0;
                w_dat_oe = 1'b1;
            end
            S_WR_PULSE: begin
                w_cs_n   = 1'b0;
                w_we_n   = 1'b0;
                w_dat_oe = 1'b1;
            end
            default: begin
                w_cs_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cs_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_dat_oe    <= 1'b0;
            r_adr       <= 19'd0;
            r_dat_o     <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'd0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_cs_n      <= w_cs_n;
            r_oe_n      <= w_oe_n;
            r_we_n      <= w_we_n;
            r_dat_oe    <= w_dat_oe;
            r_rsp_valid <= w_rd_done;
            if (w_accept) begin
                r_adr <= req_addr;
            end
            if (w_accept && req_we) begin
                r_dat_o <= req_wdata;
            end
            if (w_rd_done) begin
                r_rsp_rdata <= sram_dat_i;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign sram_adr    = r_adr;
    assign sram_dat_o  = r_dat_o;
    assign sram_dat_oe = r_dat_oe;
    assign sram_cs_n   = r_cs_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: A=2/U=1 instance plus an A=2/U=0
// instance for back-to-back reads, both backed by one SRAM array.
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [18:0] a_req_addr;
    logic [15:0] a_req_wdata;
    logic        a_rsp_valid;
    logic [15:0] a_rsp_rdata;
    logic [18:0] a_adr;
    logic [15:0] a_dat_o, a_dat_i;
    logic        a_dat_oe, a_cs_n, a_oe_n, a_we_n;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [18:0] b_req_addr;
    logic [15:0] b_req_wdata;
    logic        b_rsp_valid;
    logic [15:0] b_rsp_rdata;
    logic [18:0] b_adr;
    logic [15:0] b_dat_o, b_dat_i;
    logic        b_dat_oe, b_cs_n, b_oe_n, b_we_n;

    logic [15:0] mem [0:(1<<19)-1];

    int n_chk = 0;
    int n_fail = 0;

    sram_ctrl #(.ACCESS_CYCLES(2), .TURN_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .sram_adr(a_adr), .sram_dat_o(a_dat_o),
        .sram_dat_i(a_dat_i), .sram_dat_oe(a_dat_oe),
        .sram_cs_n(a_cs_n), .sram_oe_n(a_oe_n),
        .sram_we_n(a_we_n)
    );

    sram_ctrl #(.ACCESS_CYCLES(2), .TURN_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .sram_adr(b_adr), .sram_dat_o(b_dat_o),
        .sram_dat_i(b_dat_i), .sram_dat_oe(b_dat_oe),
        .sram_cs_n(b_cs_n), .sram_oe_n(b_oe_n),
        .sram_we_n(b_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: data latched at the rising end of WE.
    always @(posedge a_we_n) begin
        if (rst_n === 1'b1 && a_cs_n === 1'b0) mem[a_adr] = a_dat_o;
    end

    always_comb a_dat_i = (!a_cs_n && !a_oe_n) ? mem[a_adr] : 16'h0;
    always_comb b_dat_i = (!b_cs_n && !b_oe_n) ? mem[b_adr] : 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic        we_low_prev = 1'b0;
    logic [18:0] hold_adr;
    logic [15:0] hold_dat;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("inv_oe_vs_dat_oe", 32'(!a_oe_n && a_dat_oe), 32'(0));
            chk("inv_we_vs_oe", 32'(!a_we_n && !a_oe_n), 32'(0));
            if (!a_we_n && we_low_prev) begin
                chk("inv_we_adr_stable", 32'(a_adr), 32'(hold_adr));
                chk("inv_we_dat_stable", 32'(a_dat_o), 32'(hold_dat));
            end
            hold_adr    = a_adr;
            hold_dat    = a_dat_o;
            we_low_prev = !a_we_n;
        end
    end

    task automatic issue(input logic we, input logic [18:0] adr,
                         input logic [15:0] d);
        chk("issue_ready", 32'(a_req_ready), 32'(1));
        a_req_we    = we;
        a_req_addr  = adr;
        a_req_wdata = d;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
    endtask

    task automatic rand_inputs();
        a_req_valid = 1'($urandom);
        a_req_we    = 1'($urandom);
        a_req_addr  = 19'($urandom);
        a_req_wdata = 16'($urandom);
        b_req_valid = 1'($urandom);
        b_req_we    = 1'($urandom);
        b_req_addr  = 19'($urandom);
        b_req_wdata = 16'($urandom);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cs_n"}, 32'(a_cs_n), 32'(1));
        chk({tag, "_oe_n"}, 32'(a_oe_n), 32'(1));
        chk({tag, "_we_n"}, 32'(a_we_n), 32'(1));
        chk({tag, "_dat_oe"}, 32'(a_dat_oe), 32'(0));
        chk({tag, "_adr"}, 32'(a_adr), 32'(0));
        chk({tag, "_rsp_valid"}, 32'(a_rsp_valid), 32'(0));
        chk({tag, "_rsp_rdata"}, 32'(a_rsp_rdata), 32'(0));
        chk({tag, "_b_rsp_valid"}, 32'(b_rsp_valid), 32'(0));
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        rand_inputs();
        mem[19'h00000] = 16'h1111;
        mem[19'h7FFFF] = 16'h2222;
        mem[19'h00010] = 16'hA5A5;
        mem[19'h00030] = 16'hCAFE;

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            chk_reset_outs("rst");
            rand_inputs();
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        #1;
        chk_reset_outs("rst_rel");
        chk("rst_rel_ready", 32'(a_req_ready), 32'(1));
        chk("rst_rel_b_ready", 32'(b_req_ready), 32'(1));

        // Write 0x12345 <- 0xBEEF on the first edge after release
        issue(1'b1, 19'h12345, 16'hBEEF);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("wr_we_n_k%0d", k), 32'(a_we_n),
                32'((k == 2 || k == 3) ? 1 : 0) ^ 32'(1));
            chk($sformatf("wr_cs_n_k%0d", k), 32'(a_cs_n),
                32'((k <= 4) ? 0 : 1));
            chk($sformatf("wr_ready_k%0d", k), 32'(a_req_ready),
                32'((k == 5) ? 1 : 0));
            chk($sformatf("wr_rsp_k%0d", k), 32'(a_rsp_valid), 32'(0));
            if (k <= 4) begin
                chk($sformatf("wr_dat_oe_k%0d", k), 32'(a_dat_oe), 32'(1));
                chk($sformatf("wr_adr_k%0d", k), 32'(a_adr), 32'h12345);
                chk($sformatf("wr_dat_k%0d", k), 32'(a_dat_o), 32'hBEEF);
            end
        end
        chk("wr_mem", 32'(mem[19'h12345]), 32'hBEEF);

        // Read 0x12345 back
        issue(1'b0, 19'h12345, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("rd_oe_n_k%0d", k), 32'(a_oe_n),
                32'((k <= 2) ? 0 : 1));
            chk($sformatf("rd_dat_oe_k%0d", k), 32'(a_dat_oe), 32'(0));
            chk($sformatf("rd_rsp_k%0d", k), 32'(a_rsp_valid),
                32'((k == 3) ? 1 : 0));
            chk($sformatf("rd_ready_k%0d", k), 32'(a_req_ready),
                32'((k == 4) ? 1 : 0));
            if (k == 3) chk("rd_rdata", 32'(a_rsp_rdata), 32'hBEEF);
        end

        // Back-to-back reads with U=0, req_valid held
        b_req_we    = 1'b0;
        b_req_addr  = 19'h00000;
        b_req_valid = 1'b1;
        @(posedge clk);
        #1 b_req_addr = 19'h7FFFF;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_rsp_k%0d", k), 32'(b_rsp_valid),
                32'((k == 3 || k == 6) ? 1 : 0));
            chk($sformatf("b2b_ready_k%0d", k), 32'(b_req_ready),
                32'((k == 3 || k >= 6) ? 1 : 0));
            if (k == 1 || k == 2)
                chk($sformatf("b2b_adr_k%0d", k), 32'(b_adr), 32'h00000);
            if (k == 4 || k == 5)
                chk($sformatf("b2b_adr_k%0d", k), 32'(b_adr), 32'h7FFFF);
            if (k == 3) chk("b2b_rdata0", 32'(b_rsp_rdata), 32'h1111);
            if (k == 6) chk("b2b_rdata1", 32'(b_rsp_rdata), 32'h2222);
            if (k == 4) b_req_valid = 1'b0;
        end

        // Read immediately followed by a write
        issue(1'b0, 19'h00010, 16'h0000);
        a_req_we    = 1'b1;
        a_req_addr  = 19'h00020;
        a_req_wdata = 16'h5A5A;
        a_req_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                chk($sformatf("rw_dat_oe_k%0d", k), 32'(a_dat_oe), 32'(0));
                chk($sformatf("rw_ready_k%0d", k), 32'(a_req_ready),
                    32'(0));
            end
            if (k == 3) begin
                chk("rw_rsp", 32'(a_rsp_valid), 32'(1));
                chk("rw_rdata", 32'(a_rsp_rdata), 32'hA5A5);
            end
            if (k == 4) chk("rw_ready_k4", 32'(a_req_ready), 32'(1));
        end
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("rw_we_n_k%0d", k), 32'(a_we_n),
                32'((k == 2 || k == 3) ? 0 : 1));
        end
        chk("rw_mem", 32'(mem[19'h00020]), 32'h5A5A);

        // Reset during WR_PULSE
        issue(1'b1, 19'h00030, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_low", 32'(a_we_n), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        chk("mid_rst_ready", 32'(a_req_ready), 32'(1));
        repeat (2) begin
            @(negedge clk);
            rand_inputs();
            chk_reset_outs("mid_rst_hold");
        end
        chk("mid_mem", 32'(mem[19'h00030]), 32'hCAFE);
        @(negedge clk);
        rst_n = 1'b1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        #1;
        issue(1'b0, 19'h00030, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_oe_n_k%0d", k), 32'(a_oe_n),
                32'((k <= 2) ? 0 : 1));
            chk($sformatf("post_rsp_k%0d", k), 32'(a_rsp_valid),
                32'((k == 3) ? 1 : 0));
            if (k == 3) chk("post_rdata", 32'(a_rsp_rdata), 32'hCAFE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
